key_expand_iter: RTL

//  Iterative AES-128 key schedule. Latches a 128-bit cipher key and streams round keys
//  0..NUM_ROUNDS, one per accepted handshake, over a valid/ready interface.

---
 rtl/aes_pkg.sv | 47 ++++
 rtl/aes_sbox.sv | 33 +++
 rtl/key_expand_iter.sv | 104 ++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: widths, round count, Rcon table and word helpers.
// Used by the key schedule and reused by the cipher datapath stages.
package aes_pkg;

   localparam int AES_KEY_W  = 128;
   localparam int AES_NR_128 = 10;

   typedef logic [31:0] word_t;
   typedef logic [7:0]  byte_t;

   typedef enum logic {
      KS_IDLE,
      KS_RUN
   } ks_state_t;

   // Round constant for rounds 1..10; any other index yields zero.
   function automatic byte_t rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   // Word i of a 128-bit block; w0 is the most significant word.
   function automatic word_t key_word(input logic [AES_KEY_W-1:0] k, input logic [1:0] i);
      case (i)
         2'd0:    return k[127:96];
         2'd1:    return k[95:64];
         2'd2:    return k[63:32];
         default: return k[31:0];
      endcase
   endfunction

   function automatic word_t rot_word(input word_t w);
      return {w[23:0], w[31:24]};
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
// Pure ROM lookup so it stays shallow enough to sit in the key-schedule cycle.
module aes_sbox
   import aes_pkg::*;
(
   input  byte_t data,
   output byte_t sub
);

   // Entry for input 8'h00 sits in the most significant byte.
   localparam logic [2047:0] SBOX_ROM = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // NOTE: a constant ROM needs no reset; only real state registers get one.
   assign sub = SBOX_ROM[8*(255 - int'(data)) +: 8];

endmodule

// File: rtl/key_expand_iter.sv
// Iterative AES-128 key schedule: latches a key and streams round keys 0..NUM_ROUNDS
// over valid/ready, computing each next key from the current one in a single cycle.
module key_expand_iter
   import aes_pkg::*;
#(
   parameter int NUM_ROUNDS = AES_NR_128
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [AES_KEY_W-1:0] key_in,
   output logic                 busy,
   output logic                 rk_valid,
   input  logic                 rk_ready,
   output logic [AES_KEY_W-1:0] rk_data,
   output logic [3:0]           rk_round,
   output logic                 done
);

   localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

   ks_state_t            state, state_next;
   logic [AES_KEY_W-1:0] key_reg;
   logic [3:0]           round;
   logic                 done_q;
   logic                 load, advance, finish;

   word_t w0, w1, w2, w3, rot, sub, t;
   word_t w0n, w1n, w2n, w3n;

   assign w0  = key_word(key_reg, 2'd0);
   assign w1  = key_word(key_reg, 2'd1);
   assign w2  = key_word(key_reg, 2'd2);
   assign w3  = key_word(key_reg, 2'd3);
   assign rot = rot_word(w3);

   for (genvar i = 0; i < 4; i++) begin : g_sbox
      aes_sbox u_sbox (
         .data (rot[8*i +: 8]),
         .sub  (sub[8*i +: 8])
      );
   end

   // The constant belongs to the key being produced, hence round+1.
   assign t   = sub ^ {rcon(round + 4'd1), 24'h0};
   assign w0n = w0 ^ t;
   assign w1n = w1 ^ w0n;
   assign w2n = w2 ^ w1n;
   assign w3n = w3 ^ w2n;

   // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
   always_comb begin
      state_next = state;
      load       = 1'b0;
      advance    = 1'b0;
      finish     = 1'b0;
      unique case (state)
         KS_IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = KS_RUN;
            end
         end
         KS_RUN: begin
            if (rk_ready) begin
               if (round == LAST_ROUND) begin
                  finish     = 1'b1;
                  state_next = KS_IDLE;
               end else begin
                  advance = 1'b1;
               end
            end
         end
         default: state_next = KS_IDLE;
      endcase
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= KS_IDLE;
         key_reg <= '0;
         round   <= '0;
         done_q  <= 1'b0;
      end else begin
         state  <= state_next;
         done_q <= finish;
         if (load) begin
            key_reg <= key_in;
            round   <= '0;
         end else if (advance) begin
            key_reg <= {w0n, w1n, w2n, w3n};
            round   <= round + 4'd1;
         end
      end
   end

   assign busy     = (state == KS_RUN);
   assign rk_valid = (state == KS_RUN);
   assign rk_data  = key_reg;
   assign rk_round = round;
   assign done     = done_q;

endmodule
